alu_stim_sequencer: RTL and testbench

ALU_STIM_SEQUENCER -- requirements
Module: alu_stim_sequencer

---
 rtl/alu_stim_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alu_stim_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_stim_sequencer.sv
// Stimulus sequencer for a downstream ALU stage: walks every opcode and issues one
// corner vector followed by LFSR-derived operand vectors, each held for HOLD cycles.
module alu_stim_sequencer #(
    parameter int unsigned     N           = 5,
    parameter int unsigned     NUM_OPS     = 10,
    parameter int unsigned     VECS_PER_OP = 4,
    parameter int unsigned     HOLD        = 2,
    parameter logic [2*N-1:0]  SEED        = 10'h2A5,
    parameter logic [2*N-1:0]  TAPS        = 10'h240
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      abort,
    output logic [N-1:0]                              A,
    output logic [N-1:0]                              B,
    output logic [3:0]                                sel,
    output logic                                      vec_valid,
    output logic                                      busy,
    output logic                                      done,
    output logic [$clog2(NUM_OPS*VECS_PER_OP+1)-1:0]  vec_count
);

    localparam int unsigned LW = 2 * N;
    localparam int unsigned CW = $clog2(NUM_OPS * VECS_PER_OP + 1);
    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int unsigned IW = (VECS_PER_OP > 1) ? $clog2(VECS_PER_OP) : 1;

    localparam logic [LW-1:0] SEED_EFF  = (SEED == '0) ? LW'(1) : SEED;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(VECS_PER_OP - 1);
    localparam logic [3:0]    SEL_LAST  = 4'(NUM_OPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state, w_state;
    logic [LW-1:0]   r_lfsr,  w_lfsr, w_lfsr_adv;
    logic [HW-1:0]   r_hold,  w_hold;
    logic [IW-1:0]   r_idx,   w_idx;
    logic [3:0]      r_sel,   w_sel;
    logic [N-1:0]    r_a,     w_a;
    logic [N-1:0]    r_b,     w_b;
    logic            r_valid, w_valid;
    logic            r_busy,  w_busy;
    logic            r_done,  w_done;
    logic [CW-1:0]   r_count, w_count;

    // Fibonacci step; a zero result is forced back to 1 so the generator cannot lock up
    function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] s);
        logic [LW-1:0] n;
        n = {s[LW-2:0], ^(s & TAPS)};
        if (n == '0) n = LW'(1);
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr  <= SEED_EFF;
            r_hold  <= '0;
            r_idx   <= '0;
            r_sel   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_lfsr  <= w_lfsr;
            r_hold  <= w_hold;
            r_idx   <= w_idx;
            r_sel   <= w_sel;
            r_a     <= w_a;
            r_b     <= w_b;
            r_valid <= w_valid;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_count <= w_count;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_lfsr     = r_lfsr;
        w_lfsr_adv = r_lfsr;
        w_hold     = r_hold;
        w_idx      = r_idx;
        w_sel      = r_sel;
        w_a        = r_a;
        w_b        = r_b;
        w_valid    = r_valid;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_count    = r_count;

        case (r_state)
            S_IDLE: begin
                w_valid = 1'b0;
                w_busy  = 1'b0;
                if (start && !abort) begin
                    w_state = S_RUN;
                    w_lfsr  = SEED_EFF;
                    w_hold  = '0;
                    w_idx   = '0;
                    w_sel   = '0;
                    w_a     = '1;
                    w_b     = N'(1);
                    w_valid = 1'b1;
                    w_busy  = 1'b1;
                    w_count = CW'(1);
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state = S_IDLE;
                    w_valid = 1'b0;
                    w_busy  = 1'b0;
                    w_hold  = '0;
                    w_idx   = '0;
                end else if (r_hold != HOLD_LAST) begin
                    w_hold = r_hold + HW'(1);
                end else begin
                    // corner vectors (index 0) do not consume an LFSR state
                    w_hold     = '0;
                    w_lfsr_adv = (r_idx != '0) ? lfsr_step(r_lfsr) : r_lfsr;
                    w_lfsr     = w_lfsr_adv;
                    if (r_idx == IDX_LAST && r_sel == SEL_LAST) begin
                        w_state = S_DONE;
                        w_valid = 1'b0;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_idx   = '0;
                    end else begin
                        if (r_idx == IDX_LAST) begin
                            w_idx = '0;
                            w_sel = r_sel + 4'd1;
                            w_a   = '1;
                            w_b   = N'(1);
                        end else begin
                            w_idx = r_idx + IW'(1);
                            w_a   = w_lfsr_adv[LW-1:N];
                            w_b   = w_lfsr_adv[N-1:0];
                        end
                        w_count = r_count + CW'(1);
                    end
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
                w_valid = 1'b0;
                w_busy  = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
                w_valid = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign A         = r_a;
    assign B         = r_b;
    assign sel       = r_sel;
    assign vec_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign vec_count = r_count;

endmodule

// File: tb/tb_alu_stim_sequencer.sv
// Randomized bench for alu_stim_sequencer: a queue-free table model of the expected
// vector stream is built from the operand rules and compared cycle by cycle.
module tb_alu_stim_sequencer;

    localparam int N       = 5;
    localparam int NOPS    = 10;
    localparam int VPO     = 4;
    localparam int HOLD    = 2;
    localparam int TOTAL   = NOPS * VPO;
    localparam int RUN_CYC = TOTAL * HOLD;
    localparam int CW      = $clog2(NOPS * VPO + 1);

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [N-1:0]  A, B;
    logic [3:0]    sel;
    logic          vec_valid, busy, done;
    logic [CW-1:0] vec_count;

    int checks   = 0;
    int failures = 0;

    int exp_a [TOTAL];
    int exp_b [TOTAL];
    int exp_s [TOTAL];

    alu_stim_sequencer #(
        .N(N), .NUM_OPS(NOPS), .VECS_PER_OP(VPO), .HOLD(HOLD),
        .SEED(10'h2A5), .TAPS(10'h240)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .A(A), .B(B), .sel(sel), .vec_valid(vec_valid),
        .busy(busy), .done(done), .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected stream: opcode-major, corner vector first, then successive LFSR states
    function automatic void build_model();
        int lfsr = 'h2A5;
        int fb;
        for (int op = 0; op < NOPS; op++) begin
            for (int i = 0; i < VPO; i++) begin
                int k = op * VPO + i;
                exp_s[k] = op;
                if (i == 0) begin
                    exp_a[k] = (1 << N) - 1;
                    exp_b[k] = 1;
                end else begin
                    exp_a[k] = (lfsr >> N) & ((1 << N) - 1);
                    exp_b[k] = lfsr & ((1 << N) - 1);
                    fb   = $countones(lfsr & 'h240) % 2;
                    lfsr = ((lfsr << 1) | fb) & 'h3FF;
                    if (lfsr == 0) lfsr = 1;
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_A"},     32'(A), 0);
        check_eq({tag, "_B"},     32'(B), 0);
        check_eq({tag, "_sel"},   32'(sel), 0);
        check_eq({tag, "_valid"}, 32'(vec_valid), 0);
        check_eq({tag, "_busy"},  32'(busy), 0);
        check_eq({tag, "_done"},  32'(done), 0);
        check_eq({tag, "_count"}, 32'(vec_count), 0);
    endtask

    task automatic check_vec(input int t);
        int v = t / HOLD;
        check_eq("vec_A",     32'(A), 32'(exp_a[v]));
        check_eq("vec_B",     32'(B), 32'(exp_b[v]));
        check_eq("vec_sel",   32'(sel), 32'(exp_s[v]));
        check_eq("vec_valid", 32'(vec_valid), 1);
        check_eq("vec_busy",  32'(busy), 1);
        check_eq("vec_done",  32'(done), 0);
        check_eq("vec_count", 32'(vec_count), 32'(v + 1));
        if (v % VPO != 0) check_eq("lfsr_nonzero", 32'({A, B} != '0), 1);
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic full_run(input bit noisy);
        start_run();
        for (int t = 0; t < RUN_CYC; t++) begin
            check_vec(t);
            start = noisy ? 1'($urandom % 2) : 1'b0;
            tick();
        end
        check_eq("end_done",  32'(done), 1);
        check_eq("end_valid", 32'(vec_valid), 0);
        check_eq("end_busy",  32'(busy), 0);
        check_eq("end_count", 32'(vec_count), TOTAL);
        start = noisy ? 1'($urandom % 2) : 1'b0;
        tick();
        start = 1'b0;
        check_eq("idle_done",  32'(done), 0);
        check_eq("idle_busy",  32'(busy), 0);
        check_eq("idle_valid", 32'(vec_valid), 0);
        check_eq("idle_count", 32'(vec_count), TOTAL);
        check_eq("idle_sel",   32'(sel), 32'(exp_s[TOTAL-1]));
        check_eq("idle_A",     32'(A), 32'(exp_a[TOTAL-1]));
        check_eq("idle_B",     32'(B), 32'(exp_b[TOTAL-1]));
    endtask

    task automatic abort_run(input int t_ab);
        int v = t_ab / HOLD;
        start_run();
        for (int t = 0; t <= t_ab; t++) begin
            check_vec(t);
            if (t == t_ab) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check_eq("ab_valid", 32'(vec_valid), 0);
            check_eq("ab_busy",  32'(busy), 0);
            check_eq("ab_done",  32'(done), 0);
            check_eq("ab_count", 32'(vec_count), 32'(v + 1));
            check_eq("ab_A",     32'(A), 32'(exp_a[v]));
            check_eq("ab_B",     32'(B), 32'(exp_b[v]));
            check_eq("ab_sel",   32'(sel), 32'(exp_s[v]));
            tick();
        end
    endtask

    task automatic reset_run(input int t_rst);
        start_run();
        for (int t = 0; t <= t_rst; t++) begin
            check_vec(t);
            if (t == t_rst) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        check_reset("midrst");
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        build_model();
        tick();
        tick();
        check_reset("por");
        rst = 1'b0;
        tick();
        check_reset("por_idle");

        // start and abort together: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_eq("sa_busy",  32'(busy), 0);
        check_eq("sa_valid", 32'(vec_valid), 0);
        tick();
        check_eq("sa_busy2", 32'(busy), 0);

        full_run(1'b0);
        full_run(1'b1);
        abort_run(13);
        abort_run(RUN_CYC - 1);
        repeat (3) abort_run(int'($urandom_range(0, RUN_CYC - 1)));
        reset_run(40);
        full_run(1'b1);
        reset_run(int'($urandom_range(0, RUN_CYC - 1)));
        full_run(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
